muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit, directly downstream of the register file.
- Consumes the two read-port words rd1/rd2 plus the destination register index.
- Produces a 32-bit result, the destination index and a one-cycle valid pulse; valid drives the register-file write enable, result drives din.
- Sits beside the single-cycle ALU and handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.

---
 rtl/muldiv_pkg.sv | 50 +++++
 rtl/muldiv_step.sv | 47 ++++
 rtl/muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative RV32M multiply/divide unit.
//   muldiv_op_e    - RISC-V funct3 encodings of the eight M-extension operations
//   muldiv_state_e - control FSM states (IDLE, CALC, DONE)
//   special_result - detects divide-by-zero / signed-overflow and returns the
//                    architecturally defined result for those cases
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFFFFFF;
  localparam logic [31:0] INT_MIN    = 32'h80000000;

  typedef struct packed {
    logic        hit;
    logic [31:0] value;
  } special_t;

  // op[2] selects the divide family, op[1] selects remainder, op[0] unsigned.
  function automatic special_t special_result(muldiv_op_e op, logic [31:0] a, logic [31:0] b);
    special_t s;
    s.hit   = 1'b0;
    s.value = '0;
    if (op[2]) begin
      if (b == '0) begin
        s.hit   = 1'b1;
        s.value = op[1] ? a : DIV_ZERO_Q;
      end else if (!op[0] && (a == INT_MIN) && (b == 32'hFFFFFFFF)) begin
        s.hit   = 1'b1;
        s.value = op[1] ? '0 : INT_MIN;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
//   is_div_i - 1: restoring-divide step, 0: shift-add multiply step
//   acc_i    - upper word (partial product high / partial remainder)
//   lo_i     - lower word (multiplier bits / dividend bits shifting into quotient)
//   b_i      - multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_o    - next upper word
//   lo_o     - next lower word
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int Data_Width = 32
) (
  input  logic                  is_div_i,
  input  logic [Data_Width-1:0] acc_i,
  input  logic [Data_Width-1:0] lo_i,
  input  logic [Data_Width-1:0] b_i,
  output logic [Data_Width-1:0] acc_o,
  output logic [Data_Width-1:0] lo_o
);

  logic [Data_Width:0]   sum;
  logic [Data_Width:0]   rem_sh;
  logic [Data_Width-1:0] diff;
  logic                  ge;

  // Multiply: add multiplicand when the current multiplier LSB is set, then
  // shift the 65-bit {carry, acc, lo} right; product bits drop into lo.
  assign sum = {1'b0, acc_i} + (lo_i[0] ? {1'b0, b_i} : '0);

  // Divide: bring the next dividend bit into the remainder. The shifted
  // remainder can need 33 bits, but once the subtraction succeeds the
  // difference is below the divisor and fits in 32.
  assign rem_sh = {acc_i, lo_i[Data_Width-1]};
  assign ge     = rem_sh >= {1'b0, b_i};
  assign diff   = rem_sh[Data_Width-1:0] - b_i;

  always_comb begin
    if (is_div_i) begin
      acc_o = ge ? diff : rem_sh[Data_Width-1:0];
      lo_o  = {lo_i[Data_Width-2:0], ge};
    end else begin
      acc_o = sum[Data_Width:1];
      lo_o  = {sum[0], lo_i[Data_Width-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU), 32 single-bit steps per operation.
// Ports:
//   clk, rst (async, active-low)
//   start, op[2:0] (funct3), rs1_data, rs2_data, rd_in - request, sampled only when ready
//   kill     - abort in-flight operation, suppresses valid
//   ready    - IDLE;  busy - CALC or DONE
//   valid    - one-cycle result strobe (register-file write enable)
//   result   - result word, held until the next completion
//   rd_out   - destination index captured at accept
// Build option: define MULDIV_FASTPATH_EN to complete divide-by-zero, signed
// overflow and zero-operand MUL/MULHU directly at the accept edge.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int Data_Width    = 32,
  parameter int Address_Width = 5,
  parameter int Count_Width   = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [Data_Width-1:0]    rs1_data,
  input  logic [Data_Width-1:0]    rs2_data,
  input  logic [Address_Width-1:0] rd_in,
  input  logic                     kill,
  output logic                     ready,
  output logic                     busy,
  output logic                     valid,
  output logic [Data_Width-1:0]    result,
  output logic [Address_Width-1:0] rd_out
);

  localparam logic [Count_Width-1:0] LAST_STEP = Count_Width'(Data_Width - 1);

  muldiv_state_e state_q, state_d;
  muldiv_op_e    op_q, op_in;

  logic [Data_Width-1:0]    acc_q, lo_q, b_q, spec_val_q, result_q;
  logic                     neg_q, spec_hit_q;
  logic [Address_Width-1:0] rd_q;
  logic [Count_Width-1:0]   cnt_q;

  logic                  accept, sign_a, sign_b, a_neg, b_neg, neg_in;
  logic [Data_Width-1:0] abs_a, abs_b;
  special_t              spec_in;
  logic                  fast_hit;
  logic [Data_Width-1:0] fast_val;

  logic [Data_Width-1:0]   step_acc, step_lo, calc_res, final_res;
  logic [2*Data_Width-1:0] prod, prod_s;
  logic [Data_Width-1:0]   quo_s, rem_s;

  assign op_in  = muldiv_op_e'(op);
  assign accept = (state_q == IDLE) && start;

  // Operand signedness: MULH/DIV/REM treat both as signed, MULHSU only rs1.
  assign sign_a = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
  assign sign_b = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
  assign a_neg  = sign_a & rs1_data[Data_Width-1];
  assign b_neg  = sign_b & rs2_data[Data_Width-1];
  assign abs_a  = a_neg ? -rs1_data : rs1_data;
  assign abs_b  = b_neg ? -rs2_data : rs2_data;
  // Remainder follows the dividend's sign; products and quotients the XOR.
  assign neg_in = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);

  assign spec_in = special_result(op_in, rs1_data, rs2_data);

`ifdef MULDIV_FASTPATH_EN
  logic mul_zero;
  assign mul_zero = ((op_in == OP_MUL) || (op_in == OP_MULHU)) &&
                    ((rs1_data == '0) || (rs2_data == '0));
  assign fast_hit = spec_in.hit | mul_zero;
  assign fast_val = spec_in.hit ? spec_in.value : '0;
`else
  assign fast_hit = 1'b0;
  assign fast_val = '0;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = fast_hit ? DONE : CALC;
      CALC: begin
        if (kill)                    state_d = IDLE;
        else if (cnt_q == LAST_STEP) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ready = (state_q == IDLE);
    busy  = (state_q == CALC) || (state_q == DONE);
    valid = (state_q == DONE) && !kill;
  end

  muldiv_step #(.Data_Width(Data_Width)) u_step (
    .is_div_i (op_q[2]),
    .acc_i    (acc_q),
    .lo_i     (lo_q),
    .b_i      (b_q),
    .acc_o    (step_acc),
    .lo_o     (step_lo)
  );

  // Sign correction of the finished magnitudes; computed from the step
  // outputs so the result can be loaded on the same edge as the last step.
  assign prod   = {step_acc, step_lo};
  assign prod_s = neg_q ? -prod : prod;
  assign quo_s  = neg_q ? -step_lo : step_lo;
  assign rem_s  = neg_q ? -step_acc : step_acc;

  always_comb begin
    case (op_q)
      OP_MUL:                       calc_res = prod_s[Data_Width-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod_s[2*Data_Width-1:Data_Width];
      OP_DIV, OP_DIVU:              calc_res = quo_s;
      default:                      calc_res = rem_s;
    endcase
  end

  assign final_res = spec_hit_q ? spec_val_q : calc_res;

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= OP_MUL;
      rd_q       <= '0;
      acc_q      <= '0;
      lo_q       <= '0;
      b_q        <= '0;
      neg_q      <= 1'b0;
      spec_hit_q <= 1'b0;
      spec_val_q <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
    end else if (accept) begin
      op_q       <= op_in;
      rd_q       <= rd_in;
      acc_q      <= '0;
      // Divide shifts the dividend through lo; multiply shifts the multiplier.
      lo_q       <= op[2] ? abs_a : abs_b;
      b_q        <= op[2] ? abs_b : abs_a;
      neg_q      <= neg_in;
      spec_hit_q <= spec_in.hit;
      spec_val_q <= spec_in.value;
      cnt_q      <= '0;
      if (fast_hit) result_q <= fast_val;
    end else if ((state_q == CALC) && !kill) begin
      acc_q <= step_acc;
      lo_q  <= step_lo;
      cnt_q <= cnt_q + Count_Width'(1);
      if (cnt_q == LAST_STEP) result_q <= final_res;
    end
  end

  assign result = result_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

`ifdef MULDIV_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  op = 3'b0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd_in = '0;
  logic        ready, busy, valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int total = 0;
  int passed = 0;

  muldiv_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
    .kill     (kill),
    .ready    (ready),
    .busy     (busy),
    .valid    (valid),
    .result   (result),
    .rd_out   (rd_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  // Reference model: plain 64-bit / integer arithmetic on the architectural rules.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint    sa = longint'($signed(a));
    longint    sb = longint'($signed(b));
    longint    ua = longint'({32'b0, a});
    longint    ub = longint'({32'b0, b});
    logic [63:0] p;
    int        ia = $signed(a);
    int        ib = $signed(b);
    bit        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (o)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFFFFFF : ovf ? 32'h80000000 : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Edges after the accepting edge until valid is visible: 32 on the full path;
  // with the fast path the result is ready in the cycle right after accept (0).
  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bit special = (o[2] && b == 0) ||
                  ((o == 3'd4 || o == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) ||
                  ((o == 3'd0 || o == 3'd3) && (a == 0 || b == 0));
    return (FAST && special) ? 0 : 32;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int cyc;
    bit got;
    bit ready_low;
    @(negedge clk);
    check({tag, "_ready_idle"}, 32'(ready), 32'd1);
    start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0;
    // scramble inputs: the unit must not re-sample them
    op = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
    cyc = 0;
    got = valid;
    ready_low = !ready;
    while (!got && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (ready) ready_low = 1'b0;
      if (valid) got = 1'b1;
    end
    check({tag, "_valid_seen"}, 32'(got), 32'd1);
    check({tag, "_result"}, result, exp);
    check({tag, "_rd_out"}, 32'(rd_out), 32'(rd));
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat(o, a, b)));
    check({tag, "_ready_low"}, 32'(ready_low), 32'd1);
    $display("txn %s op=%0d a=%08h b=%08h rd=%0d result=%08h edges=%0d", tag, o, a, b, rd, result, cyc);
    @(posedge clk); #1;
    check({tag, "_valid_pulse"}, 32'(valid), 32'd0);
    check({tag, "_ready_after"}, 32'(ready), 32'd1);
    check({tag, "_result_hold"}, result, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  vec_t vecs[15];

  initial begin
    int pulses;
    logic [31:0] seen_res;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    logic [4:0]  rrd;

    vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[2]  = '{3'd3, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14};
    vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2};
    vecs[8]  = '{3'd5, 32'h1234,     32'd0,        32'hFFFFFFFF};
    vecs[9]  = '{3'd7, 32'h1234,     32'd0,        32'h1234};
    vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0};
    vecs[12] = '{3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF};
    vecs[13] = '{3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9};
    vecs[14] = '{3'd0, 32'd0,        32'd5,        32'd0};

    // reset state, asynchronous: no clock edge needed
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd_out", 32'(rd_out), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 3), vecs[i].exp);

    // start held high with changing operands: only the first capture completes
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs1_data = 32'd3; rs2_data = 32'd5; rd_in = 5'd7;
    pulses = 0; seen_res = '0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (valid) begin
        pulses++; seen_res = result; start = 1'b0;
      end else if (start) begin
        rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
      end
    end
    start = 1'b0;
    check("held_start_pulses", 32'(pulses), 32'd1);
    check("held_start_result", seen_res, 32'd15);
    check("held_start_rd", 32'(rd_out), 32'd7);
    $display("txn held_start pulses=%0d result=%08h", pulses, seen_res);

    // kill at step 10
    @(negedge clk);
    start = 1'b1; op = 3'd5; rs1_data = 32'd1000; rs2_data = 32'd3; rd_in = 5'd9;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) kill = 1'b1;
    check("kill_valid_suppressed", 32'(valid), 32'd0);
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_ready", 32'(ready), 32'd1);
    check("kill_busy", 32'(busy), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid) pulses++;
    end
    check("kill_no_pulse", 32'(pulses), 32'd0);
    $display("txn kill pulses=%0d", pulses);
    run_op("after_kill", 3'd4, 32'hFFFFFF9C, 32'd7, 5'd11, 32'hFFFFFFF2);

    // reset mid-CALC
    @(negedge clk);
    start = 1'b1; op = 3'd3; rs1_data = 32'hFFFFFFFF; rs2_data = 32'hFFFFFFFF; rd_in = 5'd12;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_rd_out", 32'(rd_out), 32'd0);
    @(negedge clk) rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid) pulses++;
    end
    check("midrst_no_pulse", 32'(pulses), 32'd0);
    $display("txn midrst pulses=%0d", pulses);

    // randomized operations against the reference model
    for (int i = 0; i < 150; i++) begin
      ro  = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      rrd = 5'($urandom);
      run_op($sformatf("rnd%0d", i), ro, ra, rb, rrd, ref_model(ro, ra, rb));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
